cpu_step_ctrl: RTL and testbench

//  Board-level sequencer that drives the cpu's load/s handshake from one debounced

---
 rtl/cpu_step_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - pushbutton-driven load/start/complete sequencer for the cpu
module cpu_step_ctrl #(
    parameter int DEBOUNCE = 50000,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_raw,
    input  logic             abort,
    input  logic             cpu_w,
    output logic             cpu_load,
    output logic             cpu_s,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Terminal counts: the counters run 0..N-1, so reaching N-1 means N cycles seen
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    logic            sync1;
    logic            sync2;
    logic            deb_level;
    logic            deb_prev;
    logic [DB_W-1:0] deb_cnt;
    logic            press;
    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [TO_W-1:0] tcnt;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= go_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE consecutive matching samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            deb_prev <= deb_level;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DB_LAST) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DB_W'(1);
            end
        end
    end

    // One command per debounced rising edge; holding the button never repeats
    assign press = deb_level & ~deb_prev;

    // Next-state decode; abort overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (press) state_nx = S_LOAD;
            S_LOAD:    state_nx = S_START;
            S_START:   state_nx = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!cpu_w)               state_nx = S_WAIT_HI;
                else if (tcnt == TO_LAST) state_nx = S_ERR;
            end
            S_WAIT_HI: begin
                if (cpu_w)                state_nx = S_DONE;
                else if (tcnt == TO_LAST) state_nx = S_ERR;
            end
            S_DONE:    state_nx = S_IDLE;
            S_ERR:     state_nx = S_ERR;
            default:   state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Per-state dwell counter, restarted on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (state_nx != state) begin
            tcnt <= '0;
        end else if (state == S_WAIT_LO || state == S_WAIT_HI) begin
            tcnt <= tcnt + TO_W'(1);
        end
    end

    // Completed-instruction counter, bumped together with the done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (state != S_DONE && state_nx == S_DONE) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cpu_load <= (state_nx == S_LOAD);
            cpu_s    <= (state_nx == S_START);
            busy     <= (state_nx != S_IDLE);
            done     <= (state_nx == S_DONE);
            err      <= (state_nx == S_ERR);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    localparam int DEB = 8;
    localparam int TMO = 16;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          go_raw;
    logic          abort;
    logic          cpu_w = 1'b1;
    logic          cpu_load;
    logic          cpu_s;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_cnt = 0;

    // cpu model configuration (written by the driver only)
    int cfg_d1 = 1;
    int cfg_d2 = 2;

    // monitor state (written by the monitor only)
    int  drop_at = 0;
    int  raise_at = 0;
    int  load_n = 0, load_at = -1;
    int  s_at = -1;
    int  done_n = 0, done_at = -1;
    int  err_n = 0, err_at = -1;
    int  busy_n = 0;
    logic err_prev = 1'b0;

    typedef struct {
        int hold;
        int d1;
        int d2;
        bit second;
        int exp_loads;
        int exp_dones;
        int exp_errs;
        int exp_cnt;
    } vec_t;

    vec_t tbl[9];

    cpu_step_ctrl #(.DEBOUNCE(DEB), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .go_raw(go_raw),
        .abort(abort),
        .cpu_w(cpu_w),
        .cpu_load(cpu_load),
        .cpu_s(cpu_s),
        .busy(busy),
        .done(done),
        .err(err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus cpu model: w drops d1 cycles after s and rises d2 cycles later
    always @(negedge clk) begin
        if (cpu_load) begin load_n++; load_at = cyc; end
        if (cpu_s) begin
            s_at = cyc;
            drop_at = cyc + cfg_d1;
            raise_at = drop_at + cfg_d2;
        end
        if (done) begin done_n++; done_at = cyc; end
        if (err && !err_prev) begin err_n++; err_at = cyc; end
        err_prev = err;
        if (busy) busy_n++;
        cpu_w = !((cyc >= drop_at) && (cyc < raise_at));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One button command; expectations derived from the timing rules of the block
    task automatic run_cmd(input int hold, input int d1, input int d2, input bit second,
                           input string tag, output int ld, output int dn, output int er);
        int p, ld_c, s_c, e, xdone, xerr, b_load, b_done, b_err, b_busy;
        bit acc;
        cfg_d1 = d1;
        cfg_d2 = d2;
        @(negedge clk);
        #1;
        b_load = load_n; b_done = done_n; b_err = err_n; b_busy = busy_n;
        p = cyc;
        go_raw = 1'b1;
        step(hold);
        go_raw = 1'b0;
        if (second) begin
            step(p + hold + 12 - cyc);
            go_raw = 1'b1;
            step(10);
            go_raw = 1'b0;
        end
        step(90);
        ld = load_n - b_load;
        dn = done_n - b_done;
        er = err_n - b_err;
        acc = (hold >= DEB);
        ld_c = p + DEB + 3;
        s_c = ld_c + 1;
        xdone = -1;
        xerr = -1;
        if (acc) begin
            if (d1 >= TMO) begin
                xerr = s_c + TMO + 1;
            end else if (d2 >= TMO) begin
                e = s_c + ((d1 > 0) ? d1 : 1) + 1;
                xerr = e + TMO;
            end else begin
                xdone = s_c + d1 + d2 + 1;
            end
        end
        chk({tag, " loads"}, ld, acc ? 1 : 0);
        if (acc) begin
            chk({tag, " load_at"}, load_at, ld_c);
            chk({tag, " s_at"}, s_at, s_c);
        end else begin
            chk({tag, " busy_cycles"}, busy_n - b_busy, 0);
        end
        chk({tag, " dones"}, dn, (xdone >= 0) ? 1 : 0);
        if (xdone >= 0) begin
            chk({tag, " done_at"}, done_at, xdone);
            chk({tag, " busy_cycles"}, busy_n - b_busy, xdone - ld_c + 1);
            model_cnt = (model_cnt + 1) % (1 << CW);
        end
        chk({tag, " errs"}, er, (xerr >= 0) ? 1 : 0);
        if (xerr >= 0) begin
            chk({tag, " err_at"}, err_at, xerr);
            abort = 1'b1;
            step(1);
            abort = 1'b0;
            chk({tag, " err_after_abort"}, int'(err), 0);
        end
        chk({tag, " busy_end"}, int'(busy), 0);
        chk({tag, " count"}, int'(instr_count), model_cnt);
    endtask

    initial begin
        int ld, dn, er, p, b_load, b_done, b_err, b_busy;
        int hold, d1, d2, mode;

        tbl[0] = '{5,  2,  3,  1'b0, 0, 0, 0, 0};
        tbl[1] = '{20, 2,  3,  1'b0, 1, 1, 0, 1};
        tbl[2] = '{12, 60, 2,  1'b0, 1, 0, 1, 1};
        tbl[3] = '{8,  10, 10, 1'b1, 1, 1, 0, 2};
        tbl[4] = '{10, 0,  2,  1'b0, 1, 1, 0, 3};
        tbl[5] = '{9,  3,  4,  1'b0, 1, 1, 0, 0};
        tbl[6] = '{9,  1,  60, 1'b0, 1, 0, 1, 0};
        tbl[7] = '{7,  2,  3,  1'b0, 0, 0, 0, 0};
        tbl[8] = '{11, 10, 10, 1'b0, 1, 1, 0, 1};

        reset = 1'b0;
        go_raw = 1'b0;
        abort = 1'b0;
        step(3);
        chk("reset outputs", {cpu_load, cpu_s, busy, done, err}, 0);
        chk("reset count", int'(instr_count), 0);
        reset = 1'b1;
        step(20);

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].hold, tbl[i].d1, tbl[i].d2, tbl[i].second,
                    $sformatf("row%0d", i), ld, dn, er);
            chk($sformatf("row%0d tbl_loads", i), ld, tbl[i].exp_loads);
            chk($sformatf("row%0d tbl_dones", i), dn, tbl[i].exp_dones);
            chk($sformatf("row%0d tbl_errs", i), er, tbl[i].exp_errs);
            chk($sformatf("row%0d tbl_count", i), int'(instr_count), tbl[i].exp_cnt);
        end

        for (int i = 0; i < 14; i++) begin
            mode = $urandom_range(0, 3);
            hold = $urandom_range(DEB, 30);
            d1 = $urandom_range(0, 10);
            d2 = $urandom_range(2, 10);
            if (mode == 0) hold = $urandom_range(1, DEB - 1);
            if (mode == 2) begin d1 = 60; d2 = 2; end
            if (mode == 3) d2 = 60;
            run_cmd(hold, d1, d2, 1'b0, $sformatf("rnd%0d", i), ld, dn, er);
        end

        // abort while waiting for w high: back to idle, no done, count untouched
        cfg_d1 = 2;
        cfg_d2 = 60;
        @(negedge clk);
        #1;
        b_load = load_n; b_done = done_n; b_err = err_n;
        p = cyc;
        go_raw = 1'b1;
        step(12);
        go_raw = 1'b0;
        step(p + 18 - cyc);
        chk("abort busy_before", int'(busy), 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort busy_after", int'(busy), 0);
        step(90);
        chk("abort loads", load_n - b_load, 1);
        chk("abort dones", done_n - b_done, 0);
        chk("abort errs", err_n - b_err, 0);
        chk("abort count", int'(instr_count), model_cnt);

        // abort on the same cycle as the press pulse: press is lost
        @(negedge clk);
        #1;
        b_load = load_n; b_busy = busy_n;
        p = cyc;
        go_raw = 1'b1;
        step(DEB + 2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(p + 12 - cyc);
        go_raw = 1'b0;
        step(40);
        chk("abort_press loads", load_n - b_load, 0);
        chk("abort_press busy_cycles", busy_n - b_busy, 0);

        // asynchronous reset in the middle of WAIT_HI
        cfg_d1 = 2;
        cfg_d2 = 60;
        @(negedge clk);
        #1;
        p = cyc;
        go_raw = 1'b1;
        step(12);
        go_raw = 1'b0;
        step(p + 18 - cyc);
        chk("rst busy_before", int'(busy), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst outputs", {cpu_load, cpu_s, busy, done, err}, 0);
        chk("rst count", int'(instr_count), 0);
        model_cnt = 0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        step(90);
        run_cmd(12, 2, 3, 1'b0, "post_rst", ld, dn, er);
        chk("post_rst dones", dn, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
